// File: rtl/memory_stage_pkg.sv
// Shared types and helpers for the MEM pipeline stage and its load/store aligner.
package memory_stage_pkg;

  typedef enum logic [1:0] {
    MT_BYTE  = 2'b00,
    MT_HALF  = 2'b01,
    MT_WORD  = 2'b10,
    MT_DWORD = 2'b11
  } mem_type_e;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_e;

  // Number of address bits that select a byte within one data word.
  function automatic int off_width(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational lane logic: byte enables and store replication on one side,
// load lane extraction and sign/zero extension on the other.
module load_store_align
  import memory_stage_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int NB         = DATA_WIDTH / 8,
  localparam int OW         = off_width(DATA_WIDTH)
) (
  input  mem_type_e             st_type,
  input  logic [OW-1:0]         st_off,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [NB-1:0]         be,
  output logic [DATA_WIDTH-1:0] wdata_rep,
  input  mem_type_e             ld_type,
  input  logic [OW-1:0]         ld_off,
  input  logic                  ld_sign,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] ld_data
);

  logic [DATA_WIDTH-1:0] lane_s;

  assign lane_s = rdata >> {ld_off, 3'b000};

  // Store side: byte enables and lane-replicated write data.
  always_comb begin
    be        = '0;
    wdata_rep = '0;
    case (st_type)
      MT_BYTE: begin
        be        = NB'(1'b1) << st_off;
        wdata_rep = {NB{wdata[7:0]}};
      end
      MT_HALF: begin
        be        = NB'(2'b11) << st_off;
        wdata_rep = {(NB/2){wdata[15:0]}};
      end
      MT_WORD: begin
        be        = NB'(4'hF) << st_off;
        wdata_rep = {(NB/4){wdata[31:0]}};
      end
      MT_DWORD: begin
        be        = '1;
        wdata_rep = wdata;
      end
      default: begin
        be        = '0;
        wdata_rep = '0;
      end
    endcase
  end

  // Load side: the selected lane is already at bit 0; only extension remains.
  always_comb begin
    ld_data = lane_s;
    case (ld_type)
      MT_BYTE: begin
        if (ld_sign) ld_data = DATA_WIDTH'($signed(lane_s[7:0]));
        else         ld_data = DATA_WIDTH'(lane_s[7:0]);
      end
      MT_HALF: begin
        if (ld_sign) ld_data = DATA_WIDTH'($signed(lane_s[15:0]));
        else         ld_data = DATA_WIDTH'(lane_s[15:0]);
      end
      MT_WORD: begin
        if (ld_sign) ld_data = DATA_WIDTH'($signed(lane_s[31:0]));
        else         ld_data = DATA_WIDTH'(lane_s[31:0]);
      end
      MT_DWORD: ld_data = lane_s;
      default:  ld_data = lane_s;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: req/ready data-memory access with upstream stall,
// misalignment detection and the MEM/WB register.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_i,
  input  logic                      MemRead_i,
  input  logic                      MemWrite_i,
  input  logic [1:0]                MemType_i,
  input  logic                      MemSign_i,
  input  logic                      RegWrite_i,
  input  logic [DATA_WIDTH-1:0]     ALUResultM_i,
  input  logic [DATA_WIDTH-1:0]     WriteDataM_i,
  input  logic [DATA_WIDTH-1:0]     PCPlus4M_i,
  input  logic [REG_ADDR_WIDTH-1:0] RdM_i,
  output logic                      stall_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [ADDR_WIDTH-1:0]     mem_addr_o,
  output logic [DATA_WIDTH/8-1:0]   mem_be_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  input  logic                      mem_ready_i,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
  output logic                      valid_o,
  output logic                      RegWriteW_o,
  output logic                      misalign_o,
  output logic [DATA_WIDTH-1:0]     ALUResultW_o,
  output logic [DATA_WIDTH-1:0]     ReadDataW_o,
  output logic [DATA_WIDTH-1:0]     PCPlus4W_o,
  output logic [REG_ADDR_WIDTH-1:0] RdW_o
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int OW = off_width(DATA_WIDTH);

  state_e                    state_r, state_next_s;
  mem_type_e                 type_s, type_r;
  logic [OW-1:0]             off_s, off_r;
  logic                      sign_r, store_r, regwrite_r;
  logic [DATA_WIDTH-1:0]     alu_r, pc4_r;
  logic [REG_ADDR_WIDTH-1:0] rd_r;
  logic                      is_mem_s, misalign_s, accept_s, stall_s;
  logic [NB-1:0]             be_s;
  logic [DATA_WIDTH-1:0]     wdata_rep_s, load_data_s;

  assign type_s   = mem_type_e'(MemType_i);
  assign off_s    = ALUResultM_i[OW-1:0];
  assign is_mem_s = MemRead_i | MemWrite_i;
  assign stall_o  = stall_s & ~rst;

  load_store_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .st_type   (type_s),
    .st_off    (off_s),
    .wdata     (WriteDataM_i),
    .be        (be_s),
    .wdata_rep (wdata_rep_s),
    .ld_type   (type_r),
    .ld_off    (off_r),
    .ld_sign   (sign_r),
    .rdata     (mem_rdata_i),
    .ld_data   (load_data_s)
  );

  // Alignment check; a doubleword on a 32-bit datapath is illegal.
  always_comb begin
    misalign_s = 1'b1;
    case (type_s)
      MT_BYTE:  misalign_s = 1'b0;
      MT_HALF:  misalign_s = ALUResultM_i[0];
      MT_WORD:  misalign_s = |ALUResultM_i[1:0];
      MT_DWORD: begin
        if (DATA_WIDTH == 64) misalign_s = |ALUResultM_i[2:0];
        else                  misalign_s = 1'b1;
      end
      default:  misalign_s = 1'b1;
    endcase
  end

  // Next-state and stall decode.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    stall_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (valid_i && is_mem_s && !misalign_s) begin
          accept_s     = 1'b1;
          stall_s      = 1'b1;
          state_next_s = S_ACCESS;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_ACCESS: begin
        stall_s = 1'b1;
        if (mem_ready_i) state_next_s = S_IDLE;
        else             state_next_s = S_ACCESS;
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= state_next_s;
  end

  // Request latch, memory-side outputs and the MEM/WB register.
  always_ff @(posedge clk) begin
    if (rst) begin
      type_r       <= MT_BYTE;
      off_r        <= '0;
      sign_r       <= 1'b0;
      store_r      <= 1'b0;
      regwrite_r   <= 1'b0;
      alu_r        <= '0;
      pc4_r        <= '0;
      rd_r         <= '0;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_be_o     <= '0;
      mem_wdata_o  <= '0;
      valid_o      <= 1'b0;
      RegWriteW_o  <= 1'b0;
      misalign_o   <= 1'b0;
      ALUResultW_o <= '0;
      ReadDataW_o  <= '0;
      PCPlus4W_o   <= '0;
      RdW_o        <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            type_r      <= type_s;
            off_r       <= off_s;
            sign_r      <= MemSign_i;
            store_r     <= MemWrite_i;
            regwrite_r  <= RegWrite_i;
            alu_r       <= ALUResultM_i;
            pc4_r       <= PCPlus4M_i;
            rd_r        <= RdM_i;
            mem_req_o   <= 1'b1;
            mem_we_o    <= MemWrite_i;
            mem_addr_o  <= {ALUResultM_i[ADDR_WIDTH-1:OW], {OW{1'b0}}};
            mem_be_o    <= be_s;
            mem_wdata_o <= wdata_rep_s;
            valid_o     <= 1'b0;
            RegWriteW_o <= 1'b0;
            misalign_o  <= 1'b0;
          end else begin
            // Non-memory, misaligned or empty slot passes straight to WB.
            valid_o      <= valid_i;
            misalign_o   <= valid_i & is_mem_s & misalign_s;
            RegWriteW_o  <= valid_i & RegWrite_i & ~(is_mem_s & misalign_s);
            ALUResultW_o <= ALUResultM_i;
            ReadDataW_o  <= '0;
            PCPlus4W_o   <= PCPlus4M_i;
            RdW_o        <= RdM_i;
          end
        end
        S_ACCESS: begin
          if (mem_ready_i) begin
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_be_o     <= '0;
            mem_wdata_o  <= '0;
            valid_o      <= 1'b1;
            misalign_o   <= 1'b0;
            RegWriteW_o  <= regwrite_r & ~store_r;
            ALUResultW_o <= alu_r;
            ReadDataW_o  <= store_r ? '0 : load_data_s;
            PCPlus4W_o   <= pc4_r;
            RdW_o        <= rd_r;
          end else begin
            valid_o     <= 1'b0;
            RegWriteW_o <= 1'b0;
            misalign_o  <= 1'b0;
          end
        end
        default: begin
          valid_o     <= 1'b0;
          RegWriteW_o <= 1'b0;
          misalign_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: 32-bit and 64-bit instances, directed
// scenarios plus randomized operations checked against an arithmetic model.
module tb_memory_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, valid_i, v64, MemRead_i, MemWrite_i, MemSign_i, RegWrite_i;
  logic [1:0]  MemType_i;
  logic [4:0]  RdM_i;
  logic [31:0] alu, wd, pc4, rdata;
  logic [63:0] alu64, wd64, pc64, rdata64;
  logic        ready, ready64;

  logic        stall, req, we, vo, rwo, mis;
  logic [31:0] addr, wdo, aluw, rdw, pcw;
  logic [3:0]  be;
  logic [4:0]  rdo;
  logic        stall64, req64, we64, vo64, rwo64, mis64;
  logic [31:0] addr64;
  logic [7:0]  be64;
  logic [63:0] wdo64, aluw64, rdw64, pcw64;
  logic [4:0]  rdo64;

  int tests = 0;
  int fails = 0;

  memory_stage #(.DATA_WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .MemType_i(MemType_i), .MemSign_i(MemSign_i), .RegWrite_i(RegWrite_i),
    .ALUResultM_i(alu), .WriteDataM_i(wd), .PCPlus4M_i(pc4), .RdM_i(RdM_i),
    .stall_o(stall), .mem_req_o(req), .mem_we_o(we), .mem_addr_o(addr), .mem_be_o(be),
    .mem_wdata_o(wdo), .mem_ready_i(ready), .mem_rdata_i(rdata), .valid_o(vo),
    .RegWriteW_o(rwo), .misalign_o(mis), .ALUResultW_o(aluw), .ReadDataW_o(rdw),
    .PCPlus4W_o(pcw), .RdW_o(rdo)
  );

  memory_stage #(.DATA_WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .valid_i(v64), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .MemType_i(MemType_i), .MemSign_i(MemSign_i), .RegWrite_i(RegWrite_i),
    .ALUResultM_i(alu64), .WriteDataM_i(wd64), .PCPlus4M_i(pc64), .RdM_i(RdM_i),
    .stall_o(stall64), .mem_req_o(req64), .mem_we_o(we64), .mem_addr_o(addr64), .mem_be_o(be64),
    .mem_wdata_o(wdo64), .mem_ready_i(ready64), .mem_rdata_i(rdata64), .valid_o(vo64),
    .RegWriteW_o(rwo64), .misalign_o(mis64), .ALUResultW_o(aluw64), .ReadDataW_o(rdw64),
    .PCPlus4W_o(pcw64), .RdW_o(rdo64)
  );

  // ---------------- reference model (access size in bytes = 2**type) ----------------
  function automatic bit m_misalign(input logic [1:0] t, input logic [63:0] a, input int nb);
    int sz = 1 << t;
    if (sz > nb) return 1'b1;
    return (a % sz) != 0;
  endfunction

  function automatic logic [63:0] m_be(input logic [1:0] t, input logic [63:0] a, input int nb);
    int sz = 1 << t;
    int off = int'(a % nb);
    if (sz >= nb) return (64'd1 << nb) - 64'd1;
    return ((64'd1 << sz) - 64'd1) << off;
  endfunction

  function automatic logic [63:0] m_wdata(input logic [1:0] t, input logic [63:0] d, input int nb);
    int sz = 1 << t;
    logic [63:0] lane, r;
    if (sz >= 8) return d;
    lane = d & ((64'd1 << (8 * sz)) - 64'd1);
    r = 64'd0;
    for (int k = 0; k < nb / sz; k++) r = r | (lane << (8 * sz * k));
    return r;
  endfunction

  function automatic logic [63:0] m_load(input logic [1:0] t, input logic s, input logic [63:0] rd,
                                         input logic [63:0] a, input int nb);
    int sz = 1 << t;
    int off = int'(a % nb);
    logic [63:0] mask, v;
    mask = (sz >= 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * sz)) - 64'd1);
    v = (rd >> (8 * off)) & mask;
    if (s && sz < nb && v[8 * sz - 1]) v = v | ~mask;
    if (nb == 4) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  // One operation on the 32-bit instance; lat = ACCESS cycles until mem_ready_i.
  task automatic run_op32(input logic r, input logic w, input logic [1:0] t, input logic s,
                          input logic rw, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] p, input logic [4:0] rdi, input logic [31:0] rdat,
                          input int lat, input string tag);
    bit memop = r | w;
    bit misx  = memop && m_misalign(t, {32'd0, a}, 4);
    bit acc   = memop && !misx;
    int st = 0;
    logic [63:0] ebe, ewd, eld;
    ebe = m_be(t, {32'd0, a}, 4);
    ewd = m_wdata(t, {32'd0, d}, 4);
    eld = (acc && !w) ? m_load(t, s, {32'd0, rdat}, {32'd0, a}, 4) : 64'd0;
    @(negedge clk);
    valid_i = 1'b1; MemRead_i = r; MemWrite_i = w; MemType_i = t; MemSign_i = s;
    RegWrite_i = rw; alu = a; wd = d; pc4 = p; RdM_i = rdi; rdata = rdat; ready = 1'b0;
    #1 if (stall) st++;
    if (acc) begin
      for (int c = 1; c <= lat; c++) begin
        @(negedge clk);
        ready = (c == lat);
        #1 if (stall) st++;
        tests++;
        if ({req, we, vo} !== {1'b1, w, 1'b0}) begin
          fails++; $display("FAIL %s req/we/valid: got %b want %b", tag, {req, we, vo}, {1'b1, w, 1'b0});
        end
        tests++;
        if (addr !== (a & 32'hFFFF_FFFC)) begin
          fails++; $display("FAIL %s addr: got %h want %h", tag, addr, a & 32'hFFFF_FFFC);
        end
        tests++;
        if (be !== ebe[3:0]) begin
          fails++; $display("FAIL %s be: got %h want %h", tag, be, ebe[3:0]);
        end
        if (w) begin
          tests++;
          if (wdo !== ewd[31:0]) begin
            fails++; $display("FAIL %s wdata: got %h want %h", tag, wdo, ewd[31:0]);
          end
        end
      end
    end
    @(negedge clk);
    ready = 1'b0; valid_i = 1'b0;
    #1;
    tests++;
    if ({vo, mis, rwo, req} !== {1'b1, misx, rw & ~w & ~misx, 1'b0}) begin
      fails++; $display("FAIL %s valid/misalign/regwrite/req: got %b want %b", tag,
                        {vo, mis, rwo, req}, {1'b1, misx, rw & ~w & ~misx, 1'b0});
    end
    tests++;
    if (rdw !== eld[31:0]) begin
      fails++; $display("FAIL %s readdata: got %h want %h", tag, rdw, eld[31:0]);
    end
    tests++;
    if ({aluw, pcw, rdo} !== {a, p, rdi}) begin
      fails++; $display("FAIL %s alu/pc4/rd: got %h %h %0d want %h %h %0d", tag, aluw, pcw, rdo, a, p, rdi);
    end
    tests++;
    if (st != (acc ? lat + 1 : 0)) begin
      fails++; $display("FAIL %s stall cycles: got %0d want %0d", tag, st, acc ? lat + 1 : 0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_i = 1'b0; v64 = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0;
    MemType_i = 2'b00; MemSign_i = 1'b0; RegWrite_i = 1'b0; RdM_i = 5'd0;
    alu = 32'd0; wd = 32'd0; pc4 = 32'd0; rdata = 32'd0; ready = 1'b0;
    alu64 = 64'd0; wd64 = 64'd0; pc64 = 64'd0; rdata64 = 64'd0; ready64 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    tests++;
    if ({stall, req, we, addr, be, wdo, vo, rwo, mis, aluw, rdw, pcw, rdo} !== 168'd0) begin
      fails++; $display("FAIL reset32: got nonzero output bits %h", {stall, req, we, addr, be, wdo, vo, rwo, mis});
    end
    tests++;
    if ({stall64, req64, we64, addr64, be64, wdo64, vo64, rwo64, mis64, aluw64, rdw64, pcw64, rdo64} !== 312'd0) begin
      fails++; $display("FAIL reset64: got nonzero output bits %h", {stall64, req64, vo64, be64, rdw64});
    end
    rst = 1'b0;
  endtask

  task automatic test_nonmem();
    run_op32(1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 32'h1234, 32'h0, 32'h0000_0100, 5'd5, 32'h0, 1, "nonmem");
    @(negedge clk); #1;
    tests++;
    if ({vo, rwo} !== 2'b00) begin
      fails++; $display("FAIL bubble: got valid/regwrite %b want 00", {vo, rwo});
    end
  endtask

  task automatic test_load_byte();
    run_op32(1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 32'h103, 32'h0, 32'h204, 5'd7, 32'h80FF_FF7F, 3, "lb_signed");
    run_op32(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 32'h103, 32'h0, 32'h208, 5'd8, 32'h80FF_FF7F, 3, "lb_unsigned");
    run_op32(1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 32'h104, 32'h0, 32'h20C, 5'd9, 32'h8765_4321, 1, "lw_min_latency");
  endtask

  task automatic test_store();
    run_op32(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h202, 32'hDEAD_BEEF, 32'h300, 5'd0, 32'h0, 2, "sh");
    run_op32(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 32'h501, 32'hCAFE_F00D, 32'h304, 5'd0, 32'h1111_1111, 1, "rd_wr_store");
  endtask

  task automatic test_misalign();
    run_op32(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h301, 32'h0, 32'h400, 5'd3, 32'h0, 1, "lw_misalign");
    run_op32(1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 32'h308, 32'h0, 32'h404, 5'd4, 32'h0, 1, "dword_on_32");
  endtask

  task automatic test_reset_in_access();
    @(negedge clk);
    valid_i = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'b0; MemType_i = 2'b10; MemSign_i = 1'b0;
    RegWrite_i = 1'b1; alu = 32'h600; RdM_i = 5'd11; rdata = 32'h5555_AAAA; ready = 1'b0;
    @(negedge clk);
    valid_i = 1'b0;
    #1;
    tests++;
    if (req !== 1'b1) begin
      fails++; $display("FAIL rst_access req_before: got %b want 1", req);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if ({stall, req, we, addr, be, wdo, vo, rwo, mis, rdw} !== 104'd0) begin
      fails++; $display("FAIL rst_access outputs: got %h want 0", {stall, req, we, addr, be, vo, rwo, mis, rdw});
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    #1;
    tests++;
    if ({vo, req, stall, rwo} !== 4'b0000) begin
      fails++; $display("FAIL rst_access late_ready: got %b want 0000", {vo, req, stall, rwo});
    end
  endtask

  task automatic test_dword64();
    logic [63:0] ta [2] = '{64'h408, 64'h40C};
    logic [63:0] td [2] = '{64'h0123_4567_89AB_CDEF, 64'h8000_0001_1111_2222};
    logic [1:0]  tt [2] = '{2'b11, 2'b10};
    logic [63:0] ebe, eld;
    for (int i = 0; i < 2; i++) begin
      ebe = m_be(tt[i], ta[i], 8);
      eld = m_load(tt[i], 1'b1, td[i], ta[i], 8);
      @(negedge clk);
      v64 = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'b0; MemType_i = tt[i]; MemSign_i = 1'b1;
      RegWrite_i = 1'b1; RdM_i = 5'd9; alu64 = ta[i]; pc64 = 64'h1000 + ta[i]; rdata64 = td[i];
      @(negedge clk);
      ready64 = 1'b1;
      #1;
      tests++;
      if ({req64, be64, addr64} !== {1'b1, ebe[7:0], ta[i][31:3], 3'b000}) begin
        fails++; $display("FAIL dw64_%0d req/be/addr: got %b %h %h want 1 %h %h", i, req64, be64, addr64,
                          ebe[7:0], {ta[i][31:3], 3'b000});
      end
      @(negedge clk);
      ready64 = 1'b0; v64 = 1'b0;
      #1;
      tests++;
      if ({vo64, rwo64, rdw64} !== {2'b11, eld}) begin
        fails++; $display("FAIL dw64_%0d valid/regwrite/readdata: got %b%b %h want 11 %h", i, vo64, rwo64, rdw64, eld);
      end
    end
  endtask

  task automatic test_random();
    logic r, w, s, rw;
    logic [1:0] t;
    logic [31:0] a, d, rd;
    for (int i = 0; i < 40; i++) begin
      r  = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      t  = 2'($urandom_range(0, 3));
      s  = 1'($urandom_range(0, 1));
      rw = w ? 1'b0 : 1'($urandom_range(0, 1));
      a  = $urandom;
      if ($urandom_range(0, 2) != 0) a = a & ~((32'd1 << t) - 32'd1);
      d  = $urandom;
      rd = $urandom;
      run_op32(r, w, t, s, rw, a, d, $urandom, 5'($urandom_range(0, 31)), rd,
               $urandom_range(1, 4), $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_load_byte();
    test_store();
    test_misalign();
    test_reset_in_access();
    test_dword64();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
